axi_req_arbiter: RTL and testbench

- Shares the single AXI-lite master (start_write/start_read command port feeding the AXI-to-APB/UART path) between two requesters.
  - Requester 0: RISC-V LSU.
  - Requester 1: secondary agent, e.g. UART service/debug poller.
- Round-robin grant; one outstanding transaction at a time.
- Issues one-cycle start pulses and holds address/data/strobe stable until completion.
- Returns read data and error status per requester, with address-window decode and timeout.

---
 rtl/axi_arb_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/axi_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_req_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the two-requester AXI-lite command arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_DEC = 2'b11;

  // 33-bit compare so a window touching the top of the address space cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the side that did not win last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    gnt    = '0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI-lite command port between two requesters, one transaction at a time,
// with address-window decode and a WAIT-state timeout.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic [1:0]  req0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic [1:0]  req1_err,
  output logic        m_start_write,
  output logic        m_start_read,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_psel,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             gid_q, gid_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0][1:0]  err_q, err_d;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             sel_write;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             active;

  rr_arbiter2 u_rr (
    .req    ({req1_valid, req0_valid}),
    .last   (rr_last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    sel_write = gnt_id ? req1_write : req0_write;
    sel_addr  = gnt_id ? req1_addr  : req0_addr;
    sel_wdata = gnt_id ? req1_wdata : req0_wdata;
    sel_wstrb = gnt_id ? req1_wstrb : req0_wstrb;
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gid_d     = gid_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          gid_d   = gnt_id;
          wr_d    = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_write ? sel_wdata : '0;
          wstrb_d = sel_write ? sel_wstrb : '0;
          if (in_window(sel_addr, ADDR_BASE, ADDR_SIZE)) begin
            state_d = ISSUE;
          end else begin
            err_d[gnt_id]   = ERR_DEC;
            rdata_d[gnt_id] = '0;
            state_d         = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Completion takes priority over a timeout landing on the same cycle.
        if (m_done) begin
          rdata_d[gid_q] = wr_q ? '0 : m_rdata;
          err_d[gid_q]   = {1'b0, m_err};
          state_d        = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d[gid_q] = '0;
          err_d[gid_q]   = ERR_TMO;
          state_d        = RESP;
        end
      end
      RESP: begin
        rr_last_d = gid_q;
        wr_d      = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        wstrb_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      gid_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gid_q     <= gid_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    active        = (state_q == ISSUE) || (state_q == WAIT);
    req0_ready    = (state_q == IDLE) && gnt[0] && !i_rst;
    req1_ready    = (state_q == IDLE) && gnt[1] && !i_rst;
    req0_done     = (state_q == RESP) && !gid_q;
    req1_done     = (state_q == RESP) && gid_q;
    req0_rdata    = rdata_q[0];
    req1_rdata    = rdata_q[1];
    req0_err      = err_q[0];
    req1_err      = err_q[1];
    m_start_write = (state_q == ISSUE) && wr_q;
    m_start_read  = (state_q == ISSUE) && !wr_q;
    m_psel        = active;
    m_addr        = active ? addr_q  : '0;
    m_wdata       = active ? wdata_q : '0;
    m_wstrb       = active ? wstrb_q : '0;
    busy          = (state_q != IDLE);
    grant_id      = gid_q;
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_axi_req_arbiter;

  localparam logic [31:0] A_BASE = 32'h0000_0000;
  localparam logic [31:0] A_SIZE = 32'h0000_1000;
  localparam logic [31:0] B_BASE = 32'hFFFF_F000;
  localparam logic [31:0] B_SIZE = 32'h0000_2000;
  localparam int          TMO    = 8;

  int checks = 0;
  int errors = 0;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        req0_valid, req1_valid, req0_write, req1_write;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic [3:0]  req0_wstrb, req1_wstrb;
  logic        m_done, m_err;
  logic [31:0] m_rdata;

  logic        req0_ready, req1_ready, req0_done, req1_done;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_err, req1_err;
  logic        m_start_write, m_start_read, m_psel, busy, grant_id;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  logic        b_req0_ready, b_req1_ready, b_req0_done, b_req1_done;
  logic [31:0] b_req0_rdata, b_req1_rdata;
  logic [1:0]  b_req0_err, b_req1_err;
  logic        b_m_start_write, b_m_start_read, b_m_psel, b_busy, b_grant_id;
  logic [31:0] b_m_addr, b_m_wdata;
  logic [3:0]  b_m_wstrb;

  axi_req_arbiter #(.ADDR_BASE(A_BASE), .ADDR_SIZE(A_SIZE), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .m_start_write(m_start_write), .m_start_read(m_start_read), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_psel(m_psel), .m_done(m_done),
    .m_rdata(m_rdata), .m_err(m_err), .busy(busy), .grant_id(grant_id)
  );

  axi_req_arbiter #(.ADDR_BASE(B_BASE), .ADDR_SIZE(B_SIZE), .TIMEOUT(TMO)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req0_done(b_req0_done), .req0_rdata(b_req0_rdata), .req0_err(b_req0_err),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .req1_done(b_req1_done), .req1_rdata(b_req1_rdata), .req1_err(b_req1_err),
    .m_start_write(b_m_start_write), .m_start_read(b_m_start_read), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_psel(b_m_psel), .m_done(m_done),
    .m_rdata(m_rdata), .m_err(m_err), .busy(b_busy), .grant_id(b_grant_id)
  );

  initial forever #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang, want finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  bit model_last;

  function automatic bit mdl_in_window(input logic [31:0] a, input logic [31:0] base,
                                       input logic [31:0] size);
    longint unsigned aa, lo, hi;
    aa = {32'b0, a};
    lo = {32'b0, base};
    hi = lo + {32'b0, size};
    return (aa >= lo) && (aa < hi);
  endfunction

  function automatic int mdl_winner(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  function automatic int mdl_wait_cycles(input int d);
    return (d < TMO) ? d + 1 : TMO;
  endfunction

  function automatic int mdl_done_cycle(input bit dec, input int d);
    return dec ? 1 : 2 + mdl_wait_cycles(d);
  endfunction

  function automatic logic [1:0] mdl_err(input bit dec, input int d, input bit serr);
    if (dec) return 2'b11;
    if (d < TMO) return {1'b0, serr};
    return 2'b10;
  endfunction

  function automatic logic [31:0] mdl_rdata(input bit dec, input int d, input bit wr,
                                            input logic [31:0] srd);
    return (!dec && d < TMO && !wr) ? srd : 32'h0;
  endfunction

  // ---------------- transaction driver ----------------
  int          obs_id, obs_sw, obs_sr, obs_start_cycle, obs_psel, obs_hold_bad;
  int          obs_done_cycle, obs_both_done;
  logic [31:0] obs_rdata;
  logic [1:0]  obs_err;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_wstrb;

  // Waits for an accept, acts as the slave answering d WAIT cycles in, records what it sees.
  task automatic run_txn(input int d, input bit serr, input logic [31:0] srd, input bit drop);
    bit acc, got;
    acc = 0; got = 0;
    obs_id = -1; obs_sw = 0; obs_sr = 0; obs_start_cycle = -1; obs_psel = 0;
    obs_hold_bad = 0; obs_done_cycle = -1; obs_both_done = 0;
    obs_rdata = 'x; obs_err = 'x;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge i_clk);
      if (req0_ready || req1_ready) begin
        acc       = 1;
        obs_id    = req1_ready ? 1 : 0;
        acc_write = obs_id ? req1_write : req0_write;
        acc_addr  = obs_id ? req1_addr  : req0_addr;
        acc_wdata = obs_id ? req1_wdata : req0_wdata;
        acc_wstrb = obs_id ? req1_wstrb : req0_wstrb;
        if (req0_ready && req1_ready) obs_both_done++;
      end
      @(posedge i_clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_wait: got no ready in 50 cycles, want ready");
      return;
    end
    if (drop) begin
      if (obs_id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    for (int c = 1; c < 300 && !got; c++) begin
      m_done  = (c - 2 == d);
      m_rdata = m_done ? srd : $urandom;
      m_err   = m_done ? serr : 1'($urandom);
      @(negedge i_clk);
      if (m_start_write) begin obs_sw++; if (obs_start_cycle < 0) obs_start_cycle = c; end
      if (m_start_read)  begin obs_sr++; if (obs_start_cycle < 0) obs_start_cycle = c; end
      if (m_psel) begin
        obs_psel++;
        if (m_addr !== acc_addr || m_wdata !== (acc_write ? acc_wdata : 32'h0) ||
            m_wstrb !== (acc_write ? acc_wstrb : 4'h0)) obs_hold_bad++;
      end
      if (req0_done || req1_done) begin
        got            = 1;
        obs_done_cycle = c;
        if (req0_done && req1_done) obs_both_done++;
        if (obs_id != (req1_done ? 1 : 0)) obs_both_done++;
        obs_rdata = req1_done ? req1_rdata : req0_rdata;
        obs_err   = req1_done ? req1_err   : req0_err;
      end
      @(posedge i_clk); #1;
    end
    m_done = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done in 300 cycles, want done");
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_write = 0; req1_write = 0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    req0_wstrb = '0; req1_wstrb = '0; m_done = 0; m_err = 0; m_rdata = '0;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_last = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h10;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    checks++;
    if ({req0_ready, req1_ready, req0_done, req1_done, req0_rdata, req1_rdata, req0_err,
         req1_err, m_start_write, m_start_read, m_addr, m_wdata, m_wstrb, m_psel, busy,
         grant_id} !== '0) begin
      errors++; $display("FAIL reset_outputs_a: got nonzero output in reset, want all 0");
    end
    checks++;
    if ({b_req0_ready, b_req1_ready, b_req0_done, b_req1_done, b_req0_rdata, b_req1_rdata,
         b_req0_err, b_req1_err, b_m_start_write, b_m_start_read, b_m_addr, b_m_wdata,
         b_m_wstrb, b_m_psel, b_busy, b_grant_id} !== '0) begin
      errors++; $display("FAIL reset_outputs_b: got nonzero output in reset, want all 0");
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    req0_valid = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single_read();
    req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
    req0_wdata = $urandom; req0_wstrb = 4'hF;
    run_txn(2, 1'b0, 32'hDEADBEEF, 1'b1);
    checks++; if (obs_id !== 0) begin errors++; $display("FAIL read_grant: got %0d want 0", obs_id); end
    checks++; if (obs_sr !== 1 || obs_sw !== 0 || obs_start_cycle !== 1) begin
      errors++; $display("FAIL read_start: got rd=%0d wr=%0d at %0d want rd=1 wr=0 at 1", obs_sr, obs_sw, obs_start_cycle); end
    checks++; if (obs_done_cycle !== 5) begin errors++; $display("FAIL read_latency: got %0d want 5", obs_done_cycle); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", obs_rdata); end
    checks++; if (obs_err !== 2'b00) begin errors++; $display("FAIL read_err: got %b want 00", obs_err); end
    checks++; if (obs_hold_bad !== 0 || obs_psel !== 4) begin
      errors++; $display("FAIL read_hold: got bad=%0d psel=%0d want bad=0 psel=4", obs_hold_bad, obs_psel); end
    model_last = 1'b0;
    @(negedge i_clk);
    checks++; if (busy !== 1'b0 || req0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_after: got busy=%b rdata=%h want busy=0 rdata=deadbeef", busy, req0_rdata); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_contention();
    int exp_id, d;
    logic [31:0] srd;
    req0_valid = 1; req0_write = 0; req0_addr = 32'h100;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_id = mdl_winner(1'b1, 1'b1, model_last);
      d = $urandom_range(0, 4);
      srd = $urandom;
      run_txn(d, 1'b0, srd, 1'b0);
      checks++; if (obs_id !== exp_id) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, obs_id, exp_id); end
      checks++; if (obs_sr + obs_sw !== 1 || obs_start_cycle !== 1 || obs_both_done !== 0) begin
        errors++; $display("FAIL rr_start%0d: got starts=%0d at %0d overlap=%0d want 1 at 1 overlap=0", k, obs_sr + obs_sw, obs_start_cycle, obs_both_done); end
      checks++; if (obs_rdata !== srd) begin errors++; $display("FAIL rr_rdata%0d: got %h want %h", k, obs_rdata, srd); end
      model_last = exp_id[0];
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_write_slverr();
    logic [31:0] wd;
    wd = $urandom;
    req1_valid = 1; req1_write = 1; req1_addr = 32'h0000_0FFC; req1_wdata = wd; req1_wstrb = 4'b0011;
    run_txn(3, 1'b1, 32'h1234_5678, 1'b1);
    checks++; if (obs_id !== 1) begin errors++; $display("FAIL wr_grant: got %0d want 1", obs_id); end
    checks++; if (obs_sw !== 1 || obs_sr !== 0 || obs_start_cycle !== 1) begin
      errors++; $display("FAIL wr_start: got wr=%0d rd=%0d at %0d want wr=1 rd=0 at 1", obs_sw, obs_sr, obs_start_cycle); end
    checks++; if (obs_hold_bad !== 0 || obs_psel !== 5) begin
      errors++; $display("FAIL wr_hold: got bad=%0d psel=%0d want bad=0 psel=5", obs_hold_bad, obs_psel); end
    checks++; if (obs_err !== 2'b01) begin errors++; $display("FAIL wr_slverr: got %b want 01", obs_err); end
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", obs_rdata); end
    model_last = 1'b1;
  endtask

  task automatic test_timeout();
    req0_valid = 1; req0_write = 0; req0_addr = 32'h20;
    run_txn(1000, 1'b0, 32'hAAAA_5555, 1'b1);
    checks++; if (obs_done_cycle !== 10 || obs_err !== 2'b10) begin
      errors++; $display("FAIL tmo_fire: got cycle=%0d err=%b want cycle=10 err=10", obs_done_cycle, obs_err); end
    checks++; if (obs_rdata !== 32'h0 || obs_psel !== 9) begin
      errors++; $display("FAIL tmo_rdata: got rdata=%h psel=%0d want 0 and 9", obs_rdata, obs_psel); end
    model_last = 1'b0;
    req0_valid = 1;
    run_txn(7, 1'b0, 32'h0BAD_F00D, 1'b1);
    checks++; if (obs_done_cycle !== 10 || obs_err !== 2'b00 || obs_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL tmo_race: got cycle=%0d err=%b rdata=%h want 10 00 0badf00d", obs_done_cycle, obs_err, obs_rdata); end
  endtask

  task automatic test_decode();
    req0_valid = 1; req0_write = 0; req0_addr = A_BASE + A_SIZE;
    run_txn(0, 1'b0, 32'h1111_1111, 1'b1);
    checks++; if (obs_done_cycle !== 1 || obs_err !== 2'b11) begin
      errors++; $display("FAIL dec_edge: got cycle=%0d err=%b want cycle=1 err=11", obs_done_cycle, obs_err); end
    checks++; if (obs_sw + obs_sr !== 0 || obs_psel !== 0) begin
      errors++; $display("FAIL dec_nobus: got starts=%0d psel=%0d want 0 0", obs_sw + obs_sr, obs_psel); end
    model_last = 1'b0;
  endtask

  task automatic test_nowrap();
    bit exp_in;
    pulse_reset();
    req0_valid = 1; req0_write = 0; req0_addr = 32'h0000_0800;
    exp_in = mdl_in_window(req0_addr, B_BASE, B_SIZE);
    @(negedge i_clk);
    checks++; if (b_req0_ready !== 1'b1) begin errors++; $display("FAIL nowrap_ready: got %b want 1", b_req0_ready); end
    @(posedge i_clk); #1;
    req0_valid = 0;
    @(negedge i_clk);
    checks++; if (b_m_start_read !== exp_in || b_req0_done !== !exp_in || (!exp_in && b_req0_err !== 2'b11)) begin
      errors++; $display("FAIL nowrap_low: got start=%b done=%b err=%b want start=%b done=%b", b_m_start_read, b_req0_done, b_req0_err, exp_in, !exp_in); end
    @(posedge i_clk); #1;
    req0_valid = 1; req0_addr = 32'hFFFF_FFFC;
    exp_in = mdl_in_window(req0_addr, B_BASE, B_SIZE);
    @(negedge i_clk);
    checks++; if (b_req0_ready !== 1'b1) begin errors++; $display("FAIL nowrap_ready2: got %b want 1", b_req0_ready); end
    @(posedge i_clk); #1;
    req0_valid = 0;
    @(negedge i_clk);
    checks++; if (b_m_start_read !== exp_in || b_req0_done !== !exp_in || b_m_addr !== (exp_in ? 32'hFFFF_FFFC : 32'h0)) begin
      errors++; $display("FAIL nowrap_top: got start=%b done=%b addr=%h want start=%b done=%b", b_m_start_read, b_req0_done, b_m_addr, exp_in, !exp_in); end
    @(posedge i_clk); #1;
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1; req1_write = 1; req1_addr = 32'h40; req1_wdata = 32'hCAFE_0001; req1_wstrb = 4'hF;
    @(negedge i_clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got %b want 1", req1_ready); end
    @(posedge i_clk); #1;
    req1_valid = 0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++; if (m_psel !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_wait: got psel=%b busy=%b want 1 1", m_psel, busy); end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_last = 1'b1;
    @(negedge i_clk);
    checks++; if (busy !== 1'b0 || m_psel !== 1'b0 || req0_done !== 1'b0 || req1_done !== 1'b0 || m_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_abort: got busy=%b psel=%b done=%b%b addr=%h want all 0", busy, m_psel, req1_done, req0_done, m_addr); end
    @(posedge i_clk); #1;
    req0_valid = 1; req0_write = 0; req0_addr = 32'h44;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h48;
    run_txn(1, 1'b0, 32'h5A5A_A5A5, 1'b1);
    checks++; if (obs_id !== 0) begin errors++; $display("FAIL rst_mid_first: got %0d want 0", obs_id); end
    model_last = 1'b0;
    req0_valid = 0; req1_valid = 0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    int r, exp_id, d, exp_psel;
    bit serr, dec, wr;
    logic [31:0] srd, a;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      req0_valid = r[0]; req1_valid = r[1];
      req0_write = 1'($urandom); req1_write = 1'($urandom);
      a = $urandom_range(0, 32'h17FF); req0_addr = a & 32'hFFFF_FFFC;
      a = $urandom_range(0, 32'h17FF); req1_addr = a & 32'hFFFF_FFFC;
      req0_wdata = $urandom; req1_wdata = $urandom;
      req0_wstrb = 4'($urandom); req1_wstrb = 4'($urandom);
      d = $urandom_range(0, 11); serr = 1'($urandom); srd = $urandom;
      exp_id = mdl_winner(r[0], r[1], model_last);
      wr  = exp_id ? req1_write : req0_write;
      dec = !mdl_in_window(exp_id ? req1_addr : req0_addr, A_BASE, A_SIZE);
      exp_psel = dec ? 0 : 1 + mdl_wait_cycles(d);
      run_txn(d, serr, srd, 1'b1);
      req0_valid = 0; req1_valid = 0;
      checks++; if (obs_id !== exp_id) begin errors++; $display("FAIL rnd%0d_grant: got %0d want %0d", n, obs_id, exp_id); end
      checks++; if (obs_done_cycle !== mdl_done_cycle(dec, d)) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, obs_done_cycle, mdl_done_cycle(dec, d)); end
      checks++; if (obs_err !== mdl_err(dec, d, serr)) begin
        errors++; $display("FAIL rnd%0d_err: got %b want %b", n, obs_err, mdl_err(dec, d, serr)); end
      checks++; if (obs_rdata !== mdl_rdata(dec, d, wr, srd)) begin
        errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, obs_rdata, mdl_rdata(dec, d, wr, srd)); end
      checks++; if (obs_sw !== int'(!dec && wr) || obs_sr !== int'(!dec && !wr)) begin
        errors++; $display("FAIL rnd%0d_start: got wr=%0d rd=%0d want wr=%0d rd=%0d", n, obs_sw, obs_sr, !dec && wr, !dec && !wr); end
      checks++; if (obs_psel !== exp_psel || obs_hold_bad !== 0 || obs_both_done !== 0) begin
        errors++; $display("FAIL rnd%0d_bus: got psel=%0d bad=%0d wrongdone=%0d want psel=%0d 0 0", n, obs_psel, obs_hold_bad, obs_both_done, exp_psel); end
      model_last = exp_id[0];
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_slverr();
    test_timeout();
    test_decode();
    test_nowrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
